coin_input_conditioner: RTL and testbench

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

---
 rtl/coin_input_conditioner.sv | 136 +++++++++++++
 tb/tb_coin_input_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Input conditioning for the cabinet controls: registers and debounces joystick and coin lines,
// then shapes accepted coins into a fixed-width strobe followed by a tick-timed lockout.
module coin_input_conditioner #(
   parameter int unsigned TICK_DIV       = 1000,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned PULSE_LEN      = 16,
   parameter int unsigned LOCKOUT_LEN    = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [15:0] joy_raw_i,
   input  logic        coin_raw_i,
   output logic [15:0] joy_db_o,
   output logic        coin_db_o,
   output logic        coin_pulse_o,
   output logic        coin_busy_o,
   output logic [7:0]  coin_count_o
);

   localparam int          NumBits   = 17;
   localparam logic [15:0] TickLast  = 16'(TICK_DIV - 1);
   localparam logic [3:0]  DbLast    = 4'(DEBOUNCE_TICKS - 1);
   localparam logic [7:0]  PulseLast = 8'(PULSE_LEN - 1);
   localparam logic [7:0]  LockLen   = 8'(LOCKOUT_LEN);

   typedef enum logic [1:0] {StIdle, StPulse, StLockout} state_e;

   // Bit 16 carries the coin line, bits 15:0 the joystick lines.
   logic [NumBits-1:0]       raw_q;
   logic [NumBits-1:0]       stable_q, stable_d;
   logic [NumBits-1:0][3:0]  db_cnt_q, db_cnt_d;
   logic [15:0]              tick_cnt_q, tick_cnt_d;
   logic                     tick;

   state_e      state_q;
   logic        coin_prev_q;
   logic [7:0]  cyc_cnt_q;
   logic [7:0]  lock_cnt_q;
   logic [7:0]  count_q;
   logic        pulse_q;
   logic        busy_q;
   logic        coin_rise;

   always_comb begin
      tick       = (tick_cnt_q == TickLast);
      tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
   end

   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (tick) begin
         for (int i = 0; i < NumBits; i++) begin
            if (raw_q[i] == stable_q[i]) begin
               db_cnt_d[i] = 4'd0;
            end else if (db_cnt_q[i] == DbLast) begin
               stable_d[i] = raw_q[i];
               db_cnt_d[i] = 4'd0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         raw_q      <= '0;
         stable_q   <= '0;
         db_cnt_q   <= '0;
         tick_cnt_q <= '0;
      end else begin
         raw_q      <= {coin_raw_i, joy_raw_i};
         stable_q   <= stable_d;
         db_cnt_q   <= db_cnt_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign coin_rise = stable_q[16] & ~coin_prev_q;

   // Pulse and busy are registered alongside the state so they track it exactly.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         coin_prev_q <= 1'b0;
         cyc_cnt_q   <= '0;
         lock_cnt_q  <= '0;
         count_q     <= '0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         coin_prev_q <= stable_q[16];
         unique case (state_q)
            StIdle: begin
               if (coin_rise) begin
                  state_q   <= StPulse;
                  cyc_cnt_q <= '0;
                  count_q   <= count_q + 8'd1;
                  pulse_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            StPulse: begin
               if (cyc_cnt_q == PulseLast) begin
                  state_q    <= StLockout;
                  lock_cnt_q <= '0;
                  pulse_q    <= 1'b0;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + 8'd1;
               end
            end
            StLockout: begin
               if ((lock_cnt_q >= LockLen) && !stable_q[16]) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (tick && (lock_cnt_q < LockLen)) begin
                  lock_cnt_q <= lock_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               pulse_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign joy_db_o     = stable_q[15:0];
   assign coin_db_o    = stable_q[16];
   assign coin_pulse_o = pulse_q;
   assign coin_busy_o  = busy_q;
   assign coin_count_o = count_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: a fast instance (TICK_DIV=1) for debounce and coin shaping,
// and a slow instance (TICK_DIV=1000) for tick-spaced debounce latency.
module tb_coin_input_conditioner;

   localparam int unsigned PulseLen = 4;
   localparam int unsigned LockLen  = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] joy_raw;
   logic        coin_raw;
   logic [15:0] joy_db;
   logic        coin_db, coin_pulse, coin_busy;
   logic [7:0]  coin_count;

   logic [15:0] s_joy_raw;
   logic        s_coin_raw;
   logic [15:0] s_joy_db;
   logic        s_coin_db, s_coin_pulse, s_coin_busy;
   logic [7:0]  s_coin_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   coin_input_conditioner #(
      .TICK_DIV(1), .DEBOUNCE_TICKS(3), .PULSE_LEN(PulseLen), .LOCKOUT_LEN(LockLen)
   ) dut (
      .clk_i(clk), .reset_i(reset), .joy_raw_i(joy_raw), .coin_raw_i(coin_raw),
      .joy_db_o(joy_db), .coin_db_o(coin_db), .coin_pulse_o(coin_pulse),
      .coin_busy_o(coin_busy), .coin_count_o(coin_count)
   );

   coin_input_conditioner #(
      .TICK_DIV(1000), .DEBOUNCE_TICKS(3), .PULSE_LEN(PulseLen), .LOCKOUT_LEN(LockLen)
   ) dut_slow (
      .clk_i(clk), .reset_i(reset), .joy_raw_i(s_joy_raw), .coin_raw_i(s_coin_raw),
      .joy_db_o(s_joy_db), .coin_db_o(s_coin_db), .coin_pulse_o(s_coin_pulse),
      .coin_busy_o(s_coin_busy), .coin_count_o(s_coin_count)
   );

   typedef struct {
      logic [15:0] joy;
      int          hold;
      logic [15:0] exp_joy;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] exp_joy;
      logic        exp_coin_db;
      logic [7:0]  exp_count;
   } exp_t;

   vec_t vecs[15];
   exp_t sb[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Drives coin high for cycles 1..hi1 and hi1+lo+1..hi1+lo+hi2, then low until busy drops.
   task automatic coin_seq(input int hi1, input int lo, input int hi2,
                           output int db_rise, output int pulse_start, output int pulse_cycles,
                           output int pulse_rises, output int db_fall, output int busy_fall);
      logic p_prev, b_prev, d_prev;
      db_rise = -1; pulse_start = -1; pulse_cycles = 0; pulse_rises = 0;
      db_fall = -1; busy_fall = -1;
      p_prev = coin_pulse; b_prev = coin_busy; d_prev = coin_db;
      for (int c = 1; c <= 200; c++) begin
         coin_raw = (c <= hi1) || ((c > hi1 + lo) && (c <= hi1 + lo + hi2));
         step();
         if (coin_db && !d_prev && (db_rise < 0)) db_rise = c;
         if (!coin_db && d_prev) db_fall = c;
         if (coin_pulse) pulse_cycles++;
         if (coin_pulse && !p_prev) begin
            pulse_rises++;
            if (pulse_start < 0) pulse_start = c;
         end
         if (!coin_busy && b_prev) begin
            busy_fall = c;
            break;
         end
         p_prev = coin_pulse; b_prev = coin_busy; d_prev = coin_db;
      end
      coin_raw = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dr, ps, pc, pr, df, bf;
      int exp_count;
      int waited, bad;
      exp_t e;

      vecs[0]  = '{16'h0000, 6, 16'h0000};
      vecs[1]  = '{16'h0001, 3, 16'h0000};
      vecs[2]  = '{16'h0001, 1, 16'h0001};
      vecs[3]  = '{16'h0000, 3, 16'h0001};
      vecs[4]  = '{16'h0000, 1, 16'h0000};
      vecs[5]  = '{16'h0001, 2, 16'h0000};
      vecs[6]  = '{16'h0000, 1, 16'h0000};
      vecs[7]  = '{16'h0000, 5, 16'h0000};
      vecs[8]  = '{16'hA5C3, 4, 16'hA5C3};
      vecs[9]  = '{16'h5A3C, 3, 16'hA5C3};
      vecs[10] = '{16'h5A3C, 1, 16'h5A3C};
      vecs[11] = '{16'hFFFF, 4, 16'hFFFF};
      vecs[12] = '{16'h0000, 4, 16'h0000};
      vecs[13] = '{16'h8000, 4, 16'h8000};
      vecs[14] = '{16'h0000, 4, 16'h0000};

      reset = 1'b1; joy_raw = '0; coin_raw = 1'b0; s_joy_raw = '0; s_coin_raw = 1'b0;
      step(); step();
      check("reset_joy_db", 32'(joy_db), 0);
      check("reset_coin_db", 32'(coin_db), 0);
      check("reset_pulse", 32'(coin_pulse), 0);
      check("reset_busy", 32'(coin_busy), 0);
      check("reset_count", 32'(coin_count), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 15; i++) begin
         joy_raw = vecs[i].joy;
         sb.push_back('{$sformatf("vec%0d", i), vecs[i].exp_joy, 1'b0, 8'd0});
         repeat (vecs[i].hold) step();
         e = sb.pop_front();
         check({e.name, "_joy_db"}, 32'(joy_db), 32'(e.exp_joy));
         check({e.name, "_coin_db"}, 32'(coin_db), 32'(e.exp_coin_db));
         check({e.name, "_count"}, 32'(coin_count), 32'(e.exp_count));
      end
      exp_count = 0;

      // Long hold: lockout ticks expire while held, so release governs busy.
      coin_seq(20, 0, 0, dr, ps, pc, pr, df, bf);
      exp_count++;
      check("hold20_db_rise", dr, 4);
      check("hold20_pulse_start", ps, 5);
      check("hold20_pulse_cycles", pc, PulseLen);
      check("hold20_pulse_rises", pr, 1);
      check("hold20_db_fall", df, 24);
      check("hold20_busy_fall", bf, 25);
      check("hold20_count", 32'(coin_count), exp_count);

      // Short press: lockout tick count governs busy.
      coin_seq(5, 0, 0, dr, ps, pc, pr, df, bf);
      exp_count++;
      check("short_pulse_cycles", pc, PulseLen);
      check("short_busy_fall", bf, 5 + PulseLen + LockLen + 1);
      check("short_count", 32'(coin_count), exp_count);

      // Second press lands in lockout and must be ignored.
      coin_seq(5, 3, 5, dr, ps, pc, pr, df, bf);
      exp_count++;
      check("double_pulse_rises", pr, 1);
      check("double_pulse_cycles", pc, PulseLen);
      check("double_db_fall", df, 17);
      check("double_busy_fall", bf, 18);
      check("double_count", 32'(coin_count), exp_count);

      // Reset two cycles into PULSE with coin still held.
      coin_raw = 1'b1;
      waited = 0;
      while (!coin_pulse && waited < 20) begin
         step();
         waited++;
      end
      check("midpulse_reached", 32'(coin_pulse), 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midpulse_rst_pulse", 32'(coin_pulse), 0);
      check("midpulse_rst_busy", 32'(coin_busy), 0);
      check("midpulse_rst_count", 32'(coin_count), 0);
      check("midpulse_rst_coin_db", 32'(coin_db), 0);
      pr = 0; pc = 0;
      for (int c = 0; c < 40; c++) begin
         logic p0;
         p0 = coin_pulse;
         step();
         if (coin_pulse) pc++;
         if (coin_pulse && !p0) pr++;
      end
      check("held_after_rst_rises", pr, 1);
      check("held_after_rst_cycles", pc, PulseLen);
      check("held_after_rst_count", 32'(coin_count), 1);
      coin_raw = 1'b0;
      waited = 0;
      while (coin_busy && waited < 50) begin
         step();
         waited++;
      end
      check("held_after_rst_idle", 32'(coin_busy), 0);

      // Reset during LOCKOUT.
      coin_raw = 1'b1;
      repeat (5) step();
      coin_raw = 1'b0;
      waited = 0;
      while (!(coin_busy && !coin_pulse) && waited < 30) begin
         step();
         waited++;
      end
      check("midlock_reached", 32'(coin_busy && !coin_pulse), 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midlock_rst_busy", 32'(coin_busy), 0);
      check("midlock_rst_count", 32'(coin_count), 0);
      step();

      // Count wrap.
      bad = 0;
      for (int k = 0; k < 255; k++) begin
         coin_seq(5, 0, 0, dr, ps, pc, pr, df, bf);
         if (pr != 1 || bf < 0) bad++;
      end
      check("wrap_bad_presses", bad, 0);
      check("wrap_count_255", 32'(coin_count), 255);
      coin_seq(5, 0, 0, dr, ps, pc, pr, df, bf);
      check("wrap_count_0", 32'(coin_count), 0);

      // Slow instance: tick-spaced debounce of joystick bit 15.
      s_joy_raw = 16'h8000;
      waited = 0;
      while (!s_joy_db[15] && waited < 3500) begin
         step();
         waited++;
      end
      if (waited < 2001 || waited > 3001)
         check("slow_latency", waited, (waited < 2001) ? 2001 : 3001);
      else
         check("slow_latency_in_range", 32'(s_joy_db[15]), 1);
      check("slow_other_bits", 32'(s_joy_db[14:0]), 0);
      check("slow_coin_idle", 32'({s_coin_db, s_coin_pulse, s_coin_busy}), 0);
      check("slow_count", 32'(s_coin_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
